// File: rtl/phase_bank_pkg.sv
// Shared types and constants for the phase command engine.
package phase_bank_pkg;

    localparam int BYTE_W    = 8;
    localparam int OP_W      = 4;
    localparam int CH_W      = 16;
    localparam int BURST_MAX = 256;
    localparam int CNT_W     = 9;   // wide enough to hold 1..BURST_MAX
    localparam int IDX_W     = 8;   // burst offset 0..BURST_MAX-1
    localparam int ERR_CNT_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_SET     = 4'h1,
        OP_BURST   = 4'h2,
        OP_COMMIT  = 4'h3,
        OP_CALIB   = 4'h4,
        OP_CLRCAL  = 4'h5,
        OP_DISABLE = 4'h6
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH_LO,
        ST_CH_HI,
        ST_PH,
        ST_CNT,
        ST_DATA
    } state_e;

    // A burst count byte of zero encodes the maximum burst length.
    function automatic logic [CNT_W-1:0] burst_len(input logic [BYTE_W-1:0] n);
        return (n == '0) ? CNT_W'(BURST_MAX) : {1'b0, n};
    endfunction

endpackage

// File: rtl/phase_cmd_parser.sv
// Byte-serial command parser: RX FIFO handshake, packet FSM, idle timeout
// and error accounting. Emits single-cycle requests for the storage block.
module phase_cmd_parser
    import phase_bank_pkg::*;
#(
    parameter int NUM_CHANNELS = 256,
    parameter int PHASE_W      = 8,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BYTE_W-1:0]    rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_empty,
    output logic                 rx_rd,
    output logic                 busy,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 wr_en,
    output logic [CH_W-1:0]      wr_ch,
    output logic [PHASE_W-1:0]   wr_ph,
    output logic                 commit_req,
    output logic                 calib_req,
    output logic                 clrcal_req,
    output logic                 disable_req
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_e               state_q, state_d;
    logic                 is_burst_q, is_burst_d;
    logic [BYTE_W-1:0]    ch_lo_q, ch_lo_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 burst_err_q, burst_err_d;
    logic [TO_W-1:0]      idle_cnt_q, idle_cnt_d;
    logic                 rx_rd_q, rx_rd_d;
    logic                 pending_q, pending_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 consume;
    logic                 err_evt;
    logic [CH_W:0]        burst_addr;

    assign rx_rd   = rx_rd_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

    // Handshake, packet decode, timeout and error counting.
    always_comb begin
        state_d     = state_q;
        is_burst_d  = is_burst_q;
        ch_lo_d     = ch_lo_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        burst_err_d = burst_err_q;
        idle_cnt_d  = idle_cnt_q;
        wr_en       = 1'b0;
        wr_ch       = '0;
        wr_ph       = rx_data[PHASE_W-1:0];
        commit_req  = 1'b0;
        calib_req   = 1'b0;
        clrcal_req  = 1'b0;
        disable_req = 1'b0;
        err_evt     = 1'b0;

        // Only one read may be outstanding; a stray rx_valid is not a byte.
        consume   = rx_valid && pending_q;
        rx_rd_d   = !rx_empty && !rx_rd_q && !pending_q;
        pending_d = pending_q;
        if (rx_rd_q) begin
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end

        burst_addr = {1'b0, ch_q} + {{(CH_W+1-IDX_W){1'b0}}, idx_q};

        if (consume) begin
            idle_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    case (rx_data[7:4])
                        OP_SET: begin
                            is_burst_d = 1'b0;
                            state_d    = ST_CH_LO;
                        end
                        OP_BURST: begin
                            is_burst_d = 1'b1;
                            state_d    = ST_CH_LO;
                        end
                        OP_COMMIT:  commit_req  = 1'b1;
                        OP_CALIB:   calib_req   = 1'b1;
                        OP_CLRCAL:  clrcal_req  = 1'b1;
                        OP_DISABLE: disable_req = 1'b1;
                        default:    err_evt     = 1'b1;
                    endcase
                end
                ST_CH_LO: begin
                    ch_lo_d = rx_data;
                    state_d = ST_CH_HI;
                end
                ST_CH_HI: begin
                    ch_d    = {rx_data, ch_lo_q};
                    state_d = is_burst_q ? ST_CNT : ST_PH;
                end
                ST_PH: begin
                    if ({1'b0, ch_q} < (CH_W+1)'(NUM_CHANNELS)) begin
                        wr_en = 1'b1;
                        wr_ch = ch_q;
                    end else begin
                        err_evt = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                ST_CNT: begin
                    cnt_d       = burst_len(rx_data);
                    idx_d       = '0;
                    burst_err_d = 1'b0;
                    state_d     = ST_DATA;
                end
                ST_DATA: begin
                    // Once a burst runs off the end, the rest of it is dropped
                    // silently: one error per packet.
                    if (!burst_err_q) begin
                        if (burst_addr < (CH_W+1)'(NUM_CHANNELS)) begin
                            wr_en = 1'b1;
                            wr_ch = burst_addr[CH_W-1:0];
                        end else begin
                            err_evt     = 1'b1;
                            burst_err_d = 1'b1;
                        end
                    end
                    if ({1'b0, idx_q} + CNT_W'(1) == cnt_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // Abandon a packet whose remaining bytes never arrive.
            if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
                err_evt    = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end else begin
            idle_cnt_d = '0;
        end

        err_d     = err_evt;
        err_cnt_d = (err_evt && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
    end

    // Parser state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            is_burst_q  <= 1'b0;
            ch_lo_q     <= '0;
            ch_q        <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            burst_err_q <= 1'b0;
            idle_cnt_q  <= '0;
            rx_rd_q     <= 1'b0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            is_burst_q  <= is_burst_d;
            ch_lo_q     <= ch_lo_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            burst_err_q <= burst_err_d;
            idle_cnt_q  <= idle_cnt_d;
            rx_rd_q     <= rx_rd_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: rtl/phase_bank.sv
// Phase command engine: parser plus per-channel shadow/active/calibration
// storage and registered calibrated phase outputs.
module phase_bank
    import phase_bank_pkg::*;
#(
    parameter int NUM_CHANNELS = 256,
    parameter int PHASE_W      = 8,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BYTE_W-1:0]               rx_data,
    input  logic                            rx_valid,
    input  logic                            rx_empty,
    output logic                            rx_rd,
    output logic [NUM_CHANNELS*PHASE_W-1:0] phase_out,
    output logic [NUM_CHANNELS-1:0]         ch_en,
    output logic                            commit,
    output logic                            busy,
    output logic                            err,
    output logic [ERR_CNT_W-1:0]            err_cnt
);

    logic               wr_en;
    logic [CH_W-1:0]    wr_ch;
    logic [PHASE_W-1:0] wr_ph;
    logic               commit_req;
    logic               calib_req;
    logic               clrcal_req;
    logic               disable_req;
    logic               commit_q, commit_d;

    phase_cmd_parser #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .PHASE_W     (PHASE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_parser (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_empty   (rx_empty),
        .rx_rd      (rx_rd),
        .busy       (busy),
        .err        (err),
        .err_cnt    (err_cnt),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_ph      (wr_ph),
        .commit_req (commit_req),
        .calib_req  (calib_req),
        .clrcal_req (clrcal_req),
        .disable_req(disable_req)
    );

    assign commit   = commit_q;
    assign commit_d = commit_req;

    // Commit pulse coincides with the active bank update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q <= 1'b0;
        end else begin
            commit_q <= commit_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [PHASE_W-1:0] shadow_q, shadow_d;
            logic [PHASE_W-1:0] active_q, active_d;
            logic [PHASE_W-1:0] cal_q, cal_d;
            logic [PHASE_W-1:0] phase_q, phase_d;
            logic               written_q, written_d;
            logic               en_q, en_d;
            logic               hit;

            assign hit = wr_en && (wr_ch == CH_W'(gi));

            // Per-channel bank update; writes and commits never share a cycle.
            always_comb begin
                shadow_d  = shadow_q;
                active_d  = active_q;
                cal_d     = cal_q;
                written_d = written_q;
                en_d      = en_q;
                if (hit) begin
                    shadow_d  = wr_ph;
                    written_d = 1'b1;
                end
                if (commit_req) begin
                    active_d  = shadow_q;
                    en_d      = en_q | written_q;
                    written_d = 1'b0;
                end
                if (calib_req) begin
                    cal_d = active_q;
                end
                if (clrcal_req) begin
                    cal_d = '0;
                end
                if (disable_req) begin
                    en_d = 1'b0;
                end
                // Wraps modulo 2^PHASE_W by width truncation.
                phase_d = active_q + cal_q;
            end

            // Per-channel storage and registered output phase.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q  <= '0;
                    active_q  <= '0;
                    cal_q     <= '0;
                    phase_q   <= '0;
                    written_q <= 1'b0;
                    en_q      <= 1'b0;
                end else begin
                    shadow_q  <= shadow_d;
                    active_q  <= active_d;
                    cal_q     <= cal_d;
                    phase_q   <= phase_d;
                    written_q <= written_d;
                    en_q      <= en_d;
                end
            end

            assign phase_out[gi*PHASE_W +: PHASE_W] = phase_q;
            assign ch_en[gi]                        = en_q;
        end
    endgenerate

endmodule
